// File: rtl/cla_seq_add_ctrl.sv
// ---------------------------------------------------------------------------
// cla_seq_add_ctrl
//
// Purpose:
//   Multi-cycle add/subtract controller that time-shares one external
//   SLICE-bit carry-lookahead slice. A WIDTH-bit operation is processed one
//   chunk per cycle, LSB chunk first. The group carry ripples between chunks
//   using the slice's group propagate/generate outputs.
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready      operand handshake (in_a, in_b, in_sub)
//   out_valid/out_ready    result handshake (out_sum, out_cout, out_ovf,
//                          out_zero)
//   slice_a/b/c            chunk operands and carry-in driven to the slice
//   slice_r/p/g            slice sum, group propagate, group generate
// ---------------------------------------------------------------------------
module cla_seq_add_ctrl #(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero,
   output logic [SLICE-1:0] slice_a,
   output logic [SLICE-1:0] slice_b,
   output logic             slice_c,
   input  logic [SLICE-1:0] slice_r,
   input  logic             slice_p,
   input  logic             slice_g
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e            state_q;
   logic [WIDTH-1:0]  opA_q;
   logic [WIDTH-1:0]  opB_q;
   logic [WIDTH-1:0]  sum_q;
   logic              carry_q;
   logic [IDXW-1:0]   idx_q;
   logic              outValid_q;
   logic              cout_q;
   logic              ovf_q;
   logic              zero_q;

   logic [WIDTH-1:0]  sum_d;
   logic              carry_d;

   // Chunk selection for the shared slice. A constant-index loop is used
   // instead of a variable part-select so every select stays static. The
   // slice only sees live operands while RUN is active; otherwise it is
   // driven quiet. sum_d is the running sum with the current chunk merged in,
   // which lets the final pass compute the flags on the complete result.
   always_comb begin
      slice_a = '0;
      slice_b = '0;
      slice_c = 1'b0;
      sum_d   = sum_q;
      carry_d = slice_g | (slice_p & carry_q);
      for (int i = 0; i < NSLICE; i++) begin
         if (idx_q == IDXW'(i)) begin
            sum_d[i*SLICE +: SLICE] = slice_r;
            if (state_q == RUN) begin
               slice_a = opA_q[i*SLICE +: SLICE];
               slice_b = opB_q[i*SLICE +: SLICE];
            end
         end
      end
      if (state_q == RUN) begin
         slice_c = carry_q;
      end
   end

   // Main controller FSM. Subtraction is folded into the operand capture:
   // B is inverted and the initial carry is 1, completing the two's
   // complement. Overflow compares the sign of A against the sign of the
   // (possibly inverted) B that actually went through the adder. Result
   // registers are only written during RUN, so they hold steady in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         opA_q      <= '0;
         opB_q      <= '0;
         sum_q      <= '0;
         carry_q    <= 1'b0;
         idx_q      <= '0;
         outValid_q <= 1'b0;
         cout_q     <= 1'b0;
         ovf_q      <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  opA_q   <= in_a;
                  opB_q   <= in_sub ? ~in_b : in_b;
                  carry_q <= in_sub;
                  idx_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sum_q   <= sum_d;
               carry_q <= carry_d;
               idx_q   <= idx_q + IDXW'(1);
               if (idx_q == IDXW'(NSLICE - 1)) begin
                  idx_q      <= '0;
                  state_q    <= DONE;
                  outValid_q <= 1'b1;
                  cout_q     <= carry_d;
                  ovf_q      <= (opA_q[WIDTH-1] == opB_q[WIDTH-1]) &
                                (sum_d[WIDTH-1] != opA_q[WIDTH-1]);
                  zero_q     <= (sum_d == '0);
               end
            end
            DONE: begin
               if (out_ready) begin
                  outValid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Output mapping; in_ready is a pure decode of the state register.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = outValid_q;
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign out_ovf   = ovf_q;
   assign out_zero  = zero_q;

endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cla_seq_add_ctrl
//
// Self-checking bench for cla_seq_add_ctrl. A behavioural 16-bit CLA slice
// is modelled here and hooked to the controller. Results are compared
// against a plain-arithmetic reference model of add/subtract with carry,
// signed overflow and zero flags.
// ---------------------------------------------------------------------------
module tb_cla_seq_add_ctrl;

   localparam int W = 64;
   localparam int S = 16;
   localparam int N = W / S;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_cout;
   logic          out_ovf;
   logic          out_zero;
   logic [S-1:0]  slice_a;
   logic [S-1:0]  slice_b;
   logic          slice_c;
   logic [S-1:0]  slice_r;
   logic          slice_p;
   logic          slice_g;

   logic [S:0]    sliceNoCin;

   int checks = 0;
   int errors = 0;

   cla_seq_add_ctrl #(.WIDTH(W), .SLICE(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero),
      .slice_a   (slice_a),
      .slice_b   (slice_b),
      .slice_c   (slice_c),
      .slice_r   (slice_r),
      .slice_p   (slice_p),
      .slice_g   (slice_g)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Behavioural CLA slice: sum with carry-in, group generate is the carry
   // out with no carry-in, group propagate means every bit propagates.
   assign sliceNoCin = {1'b0, slice_a} + {1'b0, slice_b};
   assign slice_r    = slice_a + slice_b + {{(S-1){1'b0}}, slice_c};
   assign slice_g    = sliceNoCin[S];
   assign slice_p    = &(slice_a ^ slice_b);

   // Reference model from the arithmetic definition of the operation.
   function automatic void refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sub, output logic [W-1:0] s,
                                    output logic c, output logic v, output logic z);
      logic [W:0] wide;
      if (sub) begin
         s = a - b;
         c = (a >= b);
         v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
      end else begin
         wide = {1'b0, a} + {1'b0, b};
         s = wide[W-1:0];
         c = wide[W];
         v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      z = (s == '0);
   endfunction

   // Runs one operation with out_ready high and collects observations:
   // latency in edges from accept to out_valid, the result, and slice_c
   // seen on each pass. Entered #1 after an edge with in_ready high.
   task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output int lat, output logic [W-1:0] sum, output logic c,
                        output logic v, output logic z, output logic [N-1:0] passC);
      out_ready = 1'b1;
      in_a      = a;
      in_b      = b;
      in_sub    = sub;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      passC    = '0;
      passC[0] = slice_c;
      lat      = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (!out_valid && lat < N) passC[lat] = slice_c;
      end
      sum = out_sum;
      c   = out_cout;
      v   = out_ovf;
      z   = out_zero;
      @(posedge clk); #1;
   endtask

   // Reset values of every output.
   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sub    = 1'b0;
      #3;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_in_ready got %b exp 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_out_valid got %b exp 0", out_valid);
      end
      checks++;
      if ({out_sum, out_cout, out_ovf, out_zero} !== '0) begin
         errors++; $display("[TB] FAIL reset_result got %h %b%b%b exp 0", out_sum, out_cout, out_ovf, out_zero);
      end
      checks++;
      if ({slice_a, slice_b, slice_c} !== '0) begin
         errors++; $display("[TB] FAIL reset_slice got %h %h %b exp 0", slice_a, slice_b, slice_c);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Directed corner vectors with hand-derived expectations.
   task automatic test_directed();
      logic [W-1:0] va[6], vb[6], vs[6];
      logic         vsub[6], vc[6], vv[6], vz[6];
      int           lat;
      logic [W-1:0] sum;
      logic         c, v, z;
      logic [N-1:0] passC;
      va[0] = 64'h0000_0000_0000_FFFF; vb[0] = 64'd1; vsub[0] = 0; vs[0] = 64'h0000_0000_0001_0000; vc[0] = 0; vv[0] = 0; vz[0] = 0;
      va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'd1; vsub[1] = 0; vs[1] = 64'h0;                   vc[1] = 1; vv[1] = 0; vz[1] = 1;
      va[2] = 64'd5;                   vb[2] = 64'd7; vsub[2] = 1; vs[2] = 64'hFFFF_FFFF_FFFF_FFFE; vc[2] = 0; vv[2] = 0; vz[2] = 0;
      va[3] = 64'h8000_0000_0000_0000; vb[3] = 64'd1; vsub[3] = 1; vs[3] = 64'h7FFF_FFFF_FFFF_FFFF; vc[3] = 1; vv[3] = 1; vz[3] = 0;
      va[4] = 64'h4000_0000_0000_0000; vb[4] = 64'h4000_0000_0000_0000; vsub[4] = 0; vs[4] = 64'h8000_0000_0000_0000; vc[4] = 0; vv[4] = 1; vz[4] = 0;
      va[5] = 64'd7;                   vb[5] = 64'd7; vsub[5] = 1; vs[5] = 64'h0;                   vc[5] = 1; vv[5] = 0; vz[5] = 1;
      for (int i = 0; i < 6; i++) begin
         runOp(va[i], vb[i], vsub[i], lat, sum, c, v, z, passC);
         checks++;
         if (lat !== N) begin
            errors++; $display("[TB] FAIL dir%0d_latency got %0d exp %0d", i, lat, N);
         end
         checks++;
         if (sum !== vs[i]) begin
            errors++; $display("[TB] FAIL dir%0d_sum got %h exp %h", i, sum, vs[i]);
         end
         checks++;
         if (c !== vc[i]) begin
            errors++; $display("[TB] FAIL dir%0d_cout got %b exp %b", i, c, vc[i]);
         end
         checks++;
         if (v !== vv[i]) begin
            errors++; $display("[TB] FAIL dir%0d_ovf got %b exp %b", i, v, vv[i]);
         end
         checks++;
         if (z !== vz[i]) begin
            errors++; $display("[TB] FAIL dir%0d_zero got %b exp %b", i, z, vz[i]);
         end
      end
   endtask

   // Carry presented to the slice on each pass.
   task automatic test_slice_carry();
      int           lat;
      logic [W-1:0] sum;
      logic         c, v, z;
      logic [N-1:0] passC;
      runOp(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat, sum, c, v, z, passC);
      checks++;
      if (passC !== 4'b1110) begin
         errors++; $display("[TB] FAIL ripple_add_carry got %b exp 1110", passC);
      end
      runOp(64'd0, 64'd0, 1'b1, lat, sum, c, v, z, passC);
      checks++;
      if (passC !== 4'b1111) begin
         errors++; $display("[TB] FAIL ripple_sub_carry got %b exp 1111", passC);
      end
   endtask

   // Randomised operations against the reference model.
   task automatic test_random();
      int           lat;
      logic [W-1:0] a, b, sum, es;
      logic         sub, c, v, z, ec, ev, ez;
      logic [N-1:0] passC;
      for (int i = 0; i < 40; i++) begin
         a   = {$urandom, $urandom};
         b   = {$urandom, $urandom};
         sub = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0: b = a;
            1: b = W'($urandom_range(0, 3));
            2: b = ~a;
            default: ;
         endcase
         refModel(a, b, sub, es, ec, ev, ez);
         runOp(a, b, sub, lat, sum, c, v, z, passC);
         checks++;
         if ({lat == N, sum, c, v, z} !== {1'b1, es, ec, ev, ez}) begin
            errors++;
            $display("[TB] FAIL rand%0d a=%h b=%h sub=%b got lat=%0d %h %b%b%b exp lat=%0d %h %b%b%b",
                     i, a, b, sub, lat, sum, c, v, z, N, es, ec, ev, ez);
         end
      end
   endtask

   // Result held under backpressure while a new request is waiting.
   task automatic test_backpressure();
      logic [W-1:0] a1, b1, a2, b2, es, held;
      logic         ec, ev, ez;
      logic [2:0]   heldFlags;
      int           lat;
      a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
      a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
      out_ready = 1'b0;
      in_a = a1; in_b = b1; in_sub = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_a = a2; in_b = b2; in_sub = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      refModel(a1, b1, 1'b1, es, ec, ev, ez);
      checks++;
      if ({out_valid, out_sum, out_cout, out_ovf, out_zero} !== {1'b1, es, ec, ev, ez}) begin
         errors++; $display("[TB] FAIL bp_first got v=%b %h exp v=1 %h", out_valid, out_sum, es);
      end
      held      = out_sum;
      heldFlags = {out_cout, out_ovf, out_zero};
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         checks++;
         if ({out_valid, in_ready, out_sum, out_cout, out_ovf, out_zero} !== {2'b10, held, heldFlags}) begin
            errors++;
            $display("[TB] FAIL bp_hold%0d got v=%b rdy=%b %h exp v=1 rdy=0 %h", k, out_valid, in_ready, out_sum, held);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++; $display("[TB] FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL bp_second_accept got rdy=%b exp 0", in_ready);
      end
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      refModel(a2, b2, 1'b0, es, ec, ev, ez);
      checks++;
      if ({lat == N, out_sum, out_cout, out_ovf, out_zero} !== {1'b1, es, ec, ev, ez}) begin
         errors++; $display("[TB] FAIL bp_second got lat=%0d %h exp lat=%0d %h", lat, out_sum, N, es);
      end
      @(posedge clk); #1;
   endtask

   // Accept spacing with in_valid and out_ready held high.
   task automatic test_back_to_back();
      int acc[$];
      int wait_cnt;
      logic pre;
      out_ready = 1'b1;
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_sub = 1'b0;
      in_valid = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         pre = in_ready;
         @(posedge clk); #1;
         if (pre) acc.push_back(e);
      end
      in_valid = 1'b0;
      checks++;
      if (acc.size() < 2) begin
         errors++; $display("[TB] FAIL b2b_accepts got %0d exp >=2", acc.size());
      end else if (acc[1] - acc[0] !== N + 2) begin
         errors++; $display("[TB] FAIL b2b_spacing got %0d exp %0d", acc[1] - acc[0], N + 2);
      end
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 20) begin
         @(posedge clk); #1;
         wait_cnt++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL b2b_drain got rdy=%b exp 1", in_ready);
      end
   endtask

   // Reset asserted mid-operation abandons it without a result.
   task automatic test_reset_mid_op();
      int seen;
      out_ready = 1'b1;
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_sub = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++; $display("[TB] FAIL midrst_state got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
      end
      checks++;
      if ({out_sum, slice_a, slice_b, slice_c} !== '0) begin
         errors++; $display("[TB] FAIL midrst_clear got %h %h %h %b exp 0", out_sum, slice_a, slice_b, slice_c);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++;
      if (seen !== 0 || in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL midrst_no_result got valid_cycles=%0d rdy=%b exp 0 rdy=1", seen, in_ready);
      end
   endtask

   // Test sequence.
   initial begin
      test_reset();
      test_directed();
      test_slice_carry();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
